// File: rtl/shift_add_multiplier_pkg.sv
// shift_add_multiplier_pkg: FSM states, sizing constants and operand magnitude helper
package shift_add_multiplier_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX} mul_state_t;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = 32;
  localparam int MUL_CNT_W = 5;
  function automatic logic [MUL_WIDTH-1:0] mag(input logic [MUL_WIDTH-1:0] x, input logic s);
    return (s && x[MUL_WIDTH-1]) ? ~x + 1'b1 : x;
  endfunction
endpackage

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: controller bus (start/is_signed/a/b in, busy/done/product out)
interface shift_add_multiplier_if;
  import shift_add_multiplier_pkg::*;
  logic                   start;
  logic                   is_signed;
  logic [MUL_WIDTH-1:0]   a;
  logic [MUL_WIDTH-1:0]   b;
  logic                   busy;
  logic                   done;
  logic [2*MUL_WIDTH-1:0] product;
  modport master(output start, is_signed, a, b, input busy, done, product);
  modport slave(input start, is_signed, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier_adder.sv
// shift_add_multiplier_adder: W-bit ripple adder (in1_i, in2_i -> out_o, carry_o)
module shift_add_multiplier_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] in1_i,
  input  logic [W-1:0] in2_i,
  output logic [W-1:0] out_o,
  output logic         carry_o
);
  assign {carry_o, out_o} = {1'b0, in1_i} + {1'b0, in2_i};
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: radix-2 shift-add multiplier, 33-cycle latency (clk, rst, bus_s: start/is_signed/a/b -> busy/done/product)
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus_s
);
  mul_state_t             state_q, state_d;
  logic [MUL_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   neg_q, neg_d, done_q, done_d;
  logic [2*MUL_WIDTH-1:0] product_q, product_d;
  logic [MUL_WIDTH-1:0]   sum;
  logic                   carry;
  shift_add_multiplier_adder #(.W(WIDTH)) u_adder (
    .in1_i  (hi_q),
    .in2_i  (lo_q[0] ? mcand_q : '0),
    .out_o  (sum),
    .carry_o(carry)
  );
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (bus_s.start) begin
        mcand_d = mag(bus_s.a, bus_s.is_signed);
        lo_d    = mag(bus_s.b, bus_s.is_signed);
        hi_d    = '0;
        cnt_d   = '0;
        neg_d   = bus_s.is_signed & (bus_s.a[MUL_WIDTH-1] ^ bus_s.b[MUL_WIDTH-1]);
        state_d = RUN;
      end
      RUN: begin
        hi_d    = {carry, sum[MUL_WIDTH-1:1]};
        lo_d    = {sum[0], lo_q[MUL_WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == MUL_CNT_W'(MUL_ITERS - 1)) ? FIX : RUN;
      end
      FIX: begin
        product_d = neg_q ? ~{hi_q, lo_q} + 1'b1 : {hi_q, lo_q};
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end
  assign bus_s.busy    = state_q != IDLE;
  assign bus_s.done    = done_q;
  assign bus_s.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: vector table, corner sequences and random ops against an arithmetic model
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  shift_add_multiplier_if bus();
  shift_add_multiplier #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus_s(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[8];
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (!s) return {32'd0, a} * {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.is_signed = s;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.is_signed = 1'($urandom);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic run_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int lat;
    do_start(s, a, b);
    wait_done(lat);
    check({name, "_lat"}, 64'(lat), 64'd33);
    check({name, "_prod"}, bus.product, exp);
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask
  initial begin
    int lat;
    bit saw_done;
    logic s;
    logic [31:0] ra, rb;
    vecs[0] = '{1'b0, 32'd5, 32'd7, 64'd35};
    vecs[1] = '{1'b1, -32'sd10, -32'sd5, 64'd50};
    vecs[2] = '{1'b1, -32'sd10, 32'd5, 64'hFFFFFFFF_FFFFFFCE};
    vecs[3] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[6] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[7] = '{1'b1, 32'd0, 32'h80000000, 64'd0};
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_prod", bus.product, 64'd0);
    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);
    do_start(1'b0, 32'd3, 32'd4);
    check("ign_busy", 64'(bus.busy), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 32'd9;
    bus.b = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    check("ign_lat", 64'(lat + 10), 64'd33);
    check("ign_prod", bus.product, 64'd12);
    do_start(1'b0, 32'd6, 32'd6);
    check("bb_busy", 64'(bus.busy), 64'd1);
    wait_done(lat);
    check("bb_lat", 64'(lat), 64'd33);
    check("bb_prod", bus.product, 64'd36);
    do_start(1'b0, 32'd5, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_prod", bus.product, 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    run_op("after_abort", 1'b0, 32'd2, 32'd3, 64'd6);
    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom);
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'h80000000 : $urandom;
      run_op($sformatf("rand%0d", i), s, ra, rb, model(s, ra, rb));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
